// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: applies branch-unit redirects, produces the wrong-path flush and traps misaligned targets.
// Optional BRANCH_STATS_EN adds saturating redirect_cnt / ignored_cnt counters.
module pc_redirect_unit #(
  parameter int PC_W         = 9,
  parameter int RESET_PC     = 0,
  parameter int TRAP_PC      = 'h1FC,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  output logic [PC_W-1:0] Cur_PC,
  output logic            flush,
  output logic            misalign_err,
`ifdef BRANCH_STATS_EN
  output logic [31:0]     redirect_cnt,
  output logic [31:0]     ignored_cnt,
`endif
  output logic            in_shadow
);

  typedef enum logic {RUN, SHADOW} state_t;

  state_t     state;
  logic [2:0] cnt;
  logic       accept, misaligned;
  logic       unused_br;

  assign accept     = PcSel && (state == RUN);
  assign misaligned = (BrPC[1:0] != 2'b00);
  assign unused_br  = ^BrPC[31:PC_W];

  // Flush depends on PcSel and state only; stall never reaches it.
  assign flush     = accept || (state == SHADOW);
  assign in_shadow = (state == SHADOW);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Cur_PC       <= PC_W'(RESET_PC);
      state        <= RUN;
      cnt          <= 3'd0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= accept && misaligned;
      if (accept) begin
        Cur_PC <= misaligned ? PC_W'(TRAP_PC) : BrPC[PC_W-1:0];
        if (FLUSH_CYCLES > 1) begin
          state <= SHADOW;
          cnt   <= 3'(FLUSH_CYCLES - 1);
        end
      end else begin
        if (!stall)
          Cur_PC <= Cur_PC + PC_W'(4);
        // Shadow countdown runs even while stalled.
        if (state == SHADOW) begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1)
            state <= RUN;
        end
      end
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      redirect_cnt <= 32'd0;
      ignored_cnt  <= 32'd0;
    end else begin
      if (accept && redirect_cnt != 32'hFFFF_FFFF)
        redirect_cnt <= redirect_cnt + 32'd1;
      if (PcSel && state == SHADOW && ignored_cnt != 32'hFFFF_FFFF)
        ignored_cnt <= ignored_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Scoreboard bench for pc_redirect_unit: a reference model pushes expected next-cycle state, popped after each edge.
module tb_pc_redirect_unit;
  localparam int PC_W = 9;
  localparam int FC   = 2;
  localparam logic [PC_W-1:0] TRAP = 9'h1FC;

  logic            clk, reset_n, stall, PcSel;
  logic [31:0]     BrPC;
  logic [PC_W-1:0] Cur_PC;
  logic            flush, misalign_err, in_shadow;
`ifdef BRANCH_STATS_EN
  logic [31:0]     redirect_cnt, ignored_cnt;
`endif

  pc_redirect_unit #(.PC_W(PC_W), .RESET_PC(0), .TRAP_PC('h1FC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .PcSel(PcSel), .BrPC(BrPC),
    .Cur_PC(Cur_PC), .flush(flush), .misalign_err(misalign_err),
`ifdef BRANCH_STATS_EN
    .redirect_cnt(redirect_cnt), .ignored_cnt(ignored_cnt),
`endif
    .in_shadow(in_shadow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            sh;
    logic            me;
    logic [31:0]     rc;
    logic [31:0]     ic;
  } exp_t;

  exp_t q[$];
  int   n_cmp, n_err;

  // reference model state
  logic [PC_W-1:0] m_pc;
  logic            m_sh, m_me;
  int              m_cnt;
  logic [31:0]     m_rc, m_ic;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = '0; m_sh = 0; m_me = 0; m_cnt = 0; m_rc = 0; m_ic = 0;
  endtask

  task automatic do_reset();
    reset_n = 0; stall = 0; PcSel = 0; BrPC = 0;
    #1;
    model_reset();
    chk("rst_pc", 32'(Cur_PC), 32'(m_pc));
    chk("rst_flush", 32'(flush), 0);
    chk("rst_shadow", 32'(in_shadow), 0);
    chk("rst_merr", 32'(misalign_err), 0);
    @(posedge clk); #1;
    reset_n = 1;
  endtask

  // One cycle: drive, check combinational flush, push model prediction, pop after the edge.
  task automatic step(input logic s, input logic p, input logic [31:0] b);
    logic acc;
    exp_t e, o;
    stall = s; PcSel = p; BrPC = b;
    #1;
    acc = p && !m_sh;
    chk("flush", 32'(flush), 32'(acc || m_sh));
    if (acc) begin
      m_me = (b[1:0] != 2'b00);
      m_pc = m_me ? TRAP : b[PC_W-1:0];
      if (m_rc != 32'hFFFF_FFFF) m_rc++;
      if (FC > 1) begin m_sh = 1; m_cnt = FC - 1; end
    end else begin
      m_me = 0;
      if (!s) m_pc = m_pc + 9'd4;
      if (m_sh) begin
        if (p && m_ic != 32'hFFFF_FFFF) m_ic++;
        if (m_cnt == 1) m_sh = 0;
        m_cnt--;
      end
    end
    e.pc = m_pc; e.sh = m_sh; e.me = m_me; e.rc = m_rc; e.ic = m_ic;
    q.push_back(e);
    @(posedge clk); #1;
    if (q.size() == 0) begin
      chk("queue_empty", 1, 0);
    end else begin
      o = q.pop_front();
      chk("pc", 32'(Cur_PC), 32'(o.pc));
      chk("shadow", 32'(in_shadow), 32'(o.sh));
      chk("merr", 32'(misalign_err), 32'(o.me));
`ifdef BRANCH_STATS_EN
      chk("redirect_cnt", redirect_cnt, o.rc);
      chk("ignored_cnt", ignored_cnt, o.ic);
`endif
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    chk("seq_pc20", 32'(Cur_PC), 20);

    do_reset();
    step(0, 0, 0); step(0, 0, 0);
    chk("pc8", 32'(Cur_PC), 8);
    step(0, 1, 32'h40);
    chk("redir_pc", 32'(Cur_PC), 32'h40);
    step(0, 1, 32'h80);
    chk("shadow_ignore_pc", 32'(Cur_PC), 32'h44);
`ifdef BRANCH_STATS_EN
    chk("ign1", ignored_cnt, 1);
    chk("red1", redirect_cnt, 1);
`endif
    step(0, 0, 0); step(0, 0, 0);

    // misaligned target traps
    step(0, 1, 32'h42);
    chk("trap_pc", 32'(Cur_PC), 32'h1FC);
    chk("trap_merr", 32'(misalign_err), 1);
    step(0, 0, 0);
    chk("merr_pulse", 32'(misalign_err), 0);
    step(0, 0, 0);

    // redirect beats stall
    step(1, 1, 32'h20);
    chk("redir_over_stall", 32'(Cur_PC), 32'h20);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("stall_hold", 32'(Cur_PC), 32'h20);

    // wrap at top of PC space; upper BrPC bits truncated
    step(0, 1, 32'hFFFF_FFF8);
    step(0, 0, 0);
    chk("pc_1fc", 32'(Cur_PC), 32'h1FC);
    step(0, 0, 0);
    chk("wrap", 32'(Cur_PC), 0);

    // asynchronous reset mid-shadow
    step(0, 1, 32'h100);
    #2;
    reset_n = 0; PcSel = 0;
    #1;
    model_reset();
    chk("async_pc", 32'(Cur_PC), 0);
    chk("async_flush", 32'(flush), 0);
    chk("async_shadow", 32'(in_shadow), 0);
    @(posedge clk); #1;
    reset_n = 1;
    step(0, 0, 0); step(0, 0, 0);

    // random tail
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0), $urandom());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
